uart_bus_arbiter: RTL and testbench
===================================

Name: uart_bus_arbiter

Overview:
- Round-robin arbiter that shares one buffered-UART register bus (active_address, write_enable, read_enable, data_in, data_out) between NUM_MASTERS requesters.
- Sits between several bus masters (CPU shim, DMA, debug port) and a single buff_uart instance.
- Grants one master at a time and caps burst length so no master starves the others.
- Inserts one dead cycle between grants so the UART FIFOs never see enables from two masters back to back.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..8).
- ADDRESS_WIDTH, 4, width of the bus address.
- WIDTH, 8, data word width.
- MAX_BURST, 4, transfers allowed per grant before forced rotation (1..255).

Ports:
- clock  in  1  system clock; all state on posedge.
- resetn  in  1  synchronous active-low reset.
- req  in  NUM_MASTERS  per-master bus request, level, held while bus is wanted.
- gnt  out  NUM_MASTERS  one-hot grant, registered.
- m_address  in  NUM_MASTERS*ADDRESS_WIDTH  per-master address, master i in slice i.
- m_write_enable  in  NUM_MASTERS  per-master write strobe.
- m_read_enable  in  NUM_MASTERS  per-master read strobe.
- m_data_in  in  NUM_MASTERS*WIDTH  per-master write data.
- m_data_out  out  WIDTH  read data, broadcast to all masters.
- active_address  out  ADDRESS_WIDTH  to buff_uart.
- write_enable  out  1  to buff_uart.
- read_enable  out  1  to buff_uart.
- data_in  out  WIDTH  to buff_uart.
- data_out  in  WIDTH  from buff_uart.
- busy  out  1  high while any grant is active.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous, active-low (resetn), sampled on posedge.
- Reset state:
  - state=IDLE, gnt=0, busy=0.
  - last_grant=NUM_MASTERS-1, so master 0 wins the first arbitration.
  - burst_count=0.
  - Bus outputs active_address=0, write_enable=0, read_enable=0, data_in=0.
- Reset mid-grant: the next edge with resetn=0 drops gnt and the enables in that same cycle, without waiting for the burst to end.
- States: IDLE, GRANT, RELEASE.
- Arbitration, used in IDLE and on exit from RELEASE:
  - Search starts at index last_grant+1 (mod NUM_MASTERS) and takes the first asserted req.
  - The winner's gnt bit is set at the next edge, giving 1 cycle from sampled req to gnt.
  - last_grant is updated to the winner and burst_count is cleared.
  - If no req is asserted, stay IDLE.
- Bus muxing in GRANT (combinational from the granted master):
  - active_address and data_in come from the granted master.
  - write_enable = m_write_enable[g] && gnt[g]; read_enable = m_read_enable[g] && gnt[g].
  - Strobes from non-granted masters are ignored.
- Outside GRANT: all bus outputs are 0.
- m_data_out = data_out at all times (pass-through, no added latency).
- Transfer counting: a transfer is a GRANT cycle with write_enable || read_enable. Simultaneous write and read in one cycle count as 1 transfer. burst_count saturates at MAX_BURST.
- GRANT exit conditions, evaluated each edge:
  - req[g]=0 -> RELEASE. A transfer in that same cycle still completes.
  - burst_count reaches MAX_BURST (including the transfer in this cycle) and some other req[j]=1, j!=g -> RELEASE.
  - burst_count reaches MAX_BURST and no other req is pending -> stay in GRANT, burst_count=0, no dead cycle.
- RELEASE: exactly one cycle with gnt=0 and enables forced 0. Then arbitrate; go to GRANT if any req, else IDLE.
- A master may drop and re-raise req during RELEASE. It is then handled by normal round-robin, with lowest priority since it is last_grant.
- busy = (state==GRANT).
- Every output changes only on posedge, except the combinational bus mux and m_data_out.

Test Plan:
- Reset, then req=3'b001 held → gnt=001 one cycle after req is sampled. Master 0 does 2 writes, address 0x2, data 0x41 then 0x42 → write_enable high for exactly those 2 cycles with active_address=0x2 and data_in matching. Master 0 drops req → RELEASE for 1 cycle, then IDLE, gnt=000.
- All req=3'b111 held, each master strobing write every cycle, MAX_BURST=4 → grant order 0,1,2,0. Each grant has exactly 4 write_enable pulses, and exactly 1 cycle of gnt=000 between grants.
- req=3'b010 alone, continuous reads for 10 cycles → gnt stays 010 throughout with no dead cycles. read_enable is high for 10 cycles, and m_data_out follows data_out each cycle.
- Master 1 granted; master 2 asserts m_write_enable while req[2]=0 → write_enable follows master 1 only. No spurious write occurs.
- Master 0 granted mid-burst (burst_count=2), resetn=0 for 1 cycle → on that edge gnt=000, enables 0, busy=0. After release with req=3'b101, master 0 is granted first.
- Master 1 asserts m_write_enable and m_read_enable together for 4 cycles with MAX_BURST=4 and req[0] pending → 4 transfers counted, then rotation to master 0 after 1 RELEASE cycle.

Source files
------------

// File: rtl/uart_bus_arbiter_if.sv
// uart_bus_arbiter_if: shared bus between NUM_MASTERS requesters, the arbiter and one buff_uart.
//   master modport (arbiter side): samples req and per-master address/strobes/data plus
//     data_out from the UART; drives gnt, m_data_out and the muxed UART bus
//     (active_address, write_enable, read_enable, data_in).
//   slave modport (requesters + UART side): the mirror image.
interface uart_bus_arbiter_if #(
   parameter int NUM_MASTERS   = 3,
   parameter int ADDRESS_WIDTH = 4,
   parameter int WIDTH         = 8
);
   logic [NUM_MASTERS-1:0]               req;
   logic [NUM_MASTERS-1:0]               gnt;
   logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_address;
   logic [NUM_MASTERS-1:0]               m_write_enable;
   logic [NUM_MASTERS-1:0]               m_read_enable;
   logic [NUM_MASTERS*WIDTH-1:0]         m_data_in;
   logic [WIDTH-1:0]                     m_data_out;
   logic [ADDRESS_WIDTH-1:0]             active_address;
   logic                                 write_enable;
   logic                                 read_enable;
   logic [WIDTH-1:0]                     data_in;
   logic [WIDTH-1:0]                     data_out;
   modport master (
      input  req, m_address, m_write_enable, m_read_enable, m_data_in, data_out,
      output gnt, m_data_out, active_address, write_enable, read_enable, data_in
   );
   modport slave (
      output req, m_address, m_write_enable, m_read_enable, m_data_in, data_out,
      input  gnt, m_data_out, active_address, write_enable, read_enable, data_in
   );
endinterface

// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter: round-robin arbiter sharing one buff_uart register bus among NUM_MASTERS masters.
//   clock  : system clock, all state on posedge
//   resetn : synchronous active-low reset
//   bus    : uart_bus_arbiter_if.master (requests, grants, per-master strobes, muxed UART bus)
//   busy   : high while a grant is active
// Burst length is capped at MAX_BURST transfers; a single dead (RELEASE) cycle separates grants.
module uart_bus_arbiter #(
   parameter int NUM_MASTERS   = 3,
   parameter int ADDRESS_WIDTH = 4,
   parameter int WIDTH         = 8,
   parameter int MAX_BURST     = 4
) (
   input  logic                  clock,
   input  logic                  resetn,
   uart_bus_arbiter_if.master    bus,
   output logic                  busy
);
   localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t                 state, state_n;
   logic [NUM_MASTERS-1:0] gnt, gnt_n;
   logic [IW-1:0]          last_grant, last_grant_n, win;
   logic [7:0]             burst_count, burst_count_n;
   logic [8:0]             count_inc;
   logic                   found, sel, xfer, at_max, others;
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         gnt         <= '0;
         last_grant  <= IW'(NUM_MASTERS-1);
         burst_count <= '0;
      end else begin
         state       <= state_n;
         gnt         <= gnt_n;
         last_grant  <= last_grant_n;
         burst_count <= burst_count_n;
      end
   end
   // Round-robin search: start just after last_grant, last_grant itself has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = last_grant;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!found && bus.req[(int'(last_grant) + k) % NUM_MASTERS]) begin
            found = 1'b1;
            win   = IW'((int'(last_grant) + k) % NUM_MASTERS);
         end
      end
   end
   // While in GRANT, last_grant is the granted master.
   assign sel                = state == GRANT;
   assign bus.write_enable   = sel && bus.m_write_enable[last_grant] && gnt[last_grant];
   assign bus.read_enable    = sel && bus.m_read_enable[last_grant] && gnt[last_grant];
   assign bus.active_address = sel ? bus.m_address[last_grant*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
   assign bus.data_in        = sel ? bus.m_data_in[last_grant*WIDTH +: WIDTH] : '0;
   assign bus.m_data_out     = bus.data_out;
   assign bus.gnt            = gnt;
   assign busy               = sel;
   // A simultaneous write and read is a single transfer.
   assign xfer      = bus.write_enable || bus.read_enable;
   assign count_inc = {1'b0, burst_count} + 9'(xfer);
   assign at_max    = count_inc >= 9'(MAX_BURST);
   assign others    = |(bus.req & ~gnt);
   always_comb begin
      state_n       = state;
      gnt_n         = gnt;
      last_grant_n  = last_grant;
      burst_count_n = burst_count;
      unique case (state)
         IDLE, RELEASE: begin
            state_n       = found ? GRANT : IDLE;
            gnt_n         = found ? {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win : '0;
            last_grant_n  = found ? win : last_grant;
            burst_count_n = '0;
         end
         GRANT: begin
            if (!bus.req[last_grant] || (at_max && others)) begin
               state_n       = RELEASE;
               gnt_n         = '0;
               burst_count_n = '0;
            end else begin
               // Burst limit with nobody waiting: keep the bus, restart the count.
               burst_count_n = at_max ? '0 : count_inc[7:0];
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb_uart_bus_arbiter: directed self-checking bench for uart_bus_arbiter (3 masters, MAX_BURST=4).
module tb_uart_bus_arbiter;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic busy;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [2:0] exp_g [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                              3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                              3'b001};
   uart_bus_arbiter_if #(.NUM_MASTERS(3), .ADDRESS_WIDTH(4), .WIDTH(8)) bus ();
   uart_bus_arbiter #(.NUM_MASTERS(3), .ADDRESS_WIDTH(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.master),
      .busy   (busy)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock);
      #2;
   endtask
   task automatic set_master(input int i, input logic [3:0] a, input logic w, input logic r, input logic [7:0] d);
      bus.m_address[i*4 +: 4]  = a;
      bus.m_write_enable[i]    = w;
      bus.m_read_enable[i]     = r;
      bus.m_data_in[i*8 +: 8]  = d;
   endtask
   task automatic clear_all();
      bus.req            = '0;
      bus.m_address      = '0;
      bus.m_write_enable = '0;
      bus.m_read_enable  = '0;
      bus.m_data_in      = '0;
      bus.data_out       = '0;
   endtask
   initial begin
      clear_all();
      step();
      step();
      check("reset_gnt", bus.gnt, 3'b000);
      check("reset_busy", busy, 1'b0);
      check("reset_we", bus.write_enable, 1'b0);
      check("reset_addr", bus.active_address, 4'h0);
      check("reset_din", bus.data_in, 8'h00);
      // single master, two writes, then release
      resetn  = 1'b1;
      bus.req = 3'b001;
      set_master(0, 4'h2, 1'b0, 1'b0, 8'h00);
      step();
      check("t1_gnt", bus.gnt, 3'b001);
      check("t1_busy", busy, 1'b1);
      set_master(0, 4'h2, 1'b1, 1'b0, 8'h41);
      #1;
      check("t1_we0", bus.write_enable, 1'b1);
      check("t1_addr0", bus.active_address, 4'h2);
      check("t1_din0", bus.data_in, 8'h41);
      step();
      set_master(0, 4'h2, 1'b1, 1'b0, 8'h42);
      #1;
      check("t1_we1", bus.write_enable, 1'b1);
      check("t1_din1", bus.data_in, 8'h42);
      step();
      set_master(0, 4'h2, 1'b0, 1'b0, 8'h42);
      bus.req = 3'b000;
      #1;
      check("t1_we_off", bus.write_enable, 1'b0);
      step();
      check("t1_rel_gnt", bus.gnt, 3'b000);
      check("t1_rel_busy", busy, 1'b0);
      step();
      check("t1_idle_gnt", bus.gnt, 3'b000);
      check("t1_idle_busy", busy, 1'b0);
      // all masters requesting, rotation 0,1,2,0 with one dead cycle between grants
      resetn = 1'b0;
      step();
      resetn  = 1'b1;
      bus.req = 3'b111;
      set_master(0, 4'h1, 1'b1, 1'b0, 8'hA0);
      set_master(1, 4'h5, 1'b1, 1'b0, 8'hB1);
      set_master(2, 4'h9, 1'b1, 1'b0, 8'hC2);
      for (int c = 0; c < 16; c++) begin
         step();
         check($sformatf("t2_gnt%0d", c), bus.gnt, exp_g[c]);
         check($sformatf("t2_we%0d", c), bus.write_enable, |exp_g[c]);
         if (c == 5) check("t2_addr_m1", bus.active_address, 4'h5);
         if (c == 10) check("t2_din_m2", bus.data_in, 8'hC2);
      end
      clear_all();
      step();
      step();
      // lone master 1 reading continuously: no dead cycles past MAX_BURST
      bus.req = 3'b010;
      set_master(1, 4'h3, 1'b0, 1'b1, 8'h00);
      step();
      for (int i = 0; i < 10; i++) begin
         bus.data_out = 8'(8'h10 + i);
         #1;
         check($sformatf("t3_gnt%0d", i), bus.gnt, 3'b010);
         check($sformatf("t3_re%0d", i), bus.read_enable, 1'b1);
         check($sformatf("t3_dout%0d", i), bus.m_data_out, 8'(8'h10 + i));
         step();
      end
      // non-granted master's strobe is ignored
      set_master(1, 4'h7, 1'b0, 1'b0, 8'h11);
      set_master(2, 4'hF, 1'b1, 1'b0, 8'hEE);
      #1;
      check("t4_no_spurious_we", bus.write_enable, 1'b0);
      check("t4_addr_m1", bus.active_address, 4'h7);
      set_master(1, 4'h7, 1'b1, 1'b0, 8'h11);
      #1;
      check("t4_we_m1", bus.write_enable, 1'b1);
      check("t4_din_m1", bus.data_in, 8'h11);
      step();
      check("t4_gnt", bus.gnt, 3'b010);
      clear_all();
      step();
      step();
      // reset mid-burst, then master 0 wins first
      bus.req = 3'b001;
      step();
      check("t5_gnt", bus.gnt, 3'b001);
      set_master(0, 4'h4, 1'b1, 1'b0, 8'h55);
      step();
      step();
      resetn = 1'b0;
      step();
      check("t5_rst_gnt", bus.gnt, 3'b000);
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_we", bus.write_enable, 1'b0);
      resetn  = 1'b1;
      bus.req = 3'b101;
      set_master(0, 4'h4, 1'b0, 1'b0, 8'h55);
      step();
      check("t5_after_gnt", bus.gnt, 3'b001);
      // master 1 write+read together counts once per cycle, rotation after 4 cycles
      bus.req = 3'b010;
      step();
      check("t6_rel_gnt", bus.gnt, 3'b000);
      bus.req = 3'b011;
      step();
      check("t6_gnt_m1", bus.gnt, 3'b010);
      set_master(1, 4'h6, 1'b1, 1'b1, 8'h66);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t6_we%0d", i), bus.write_enable, 1'b1);
         check($sformatf("t6_re%0d", i), bus.read_enable, 1'b1);
         check($sformatf("t6_gnt%0d", i), bus.gnt, 3'b010);
         step();
      end
      check("t6_dead_gnt", bus.gnt, 3'b000);
      check("t6_dead_busy", busy, 1'b0);
      check("t6_dead_we", bus.write_enable, 1'b0);
      check("t6_dead_re", bus.read_enable, 1'b0);
      step();
      check("t6_rot_gnt", bus.gnt, 3'b001);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
